// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the ADDU..BR opcode set.
// Single-cycle ops finish one cycle after accept. SRA/SLG by n>0 run an
// iterative 1-bit/cycle shifter and finish 1+n cycles after accept.
// A persistent carry register is updated only when an op completes.
//
// Handshake rules:
//   Input side: an op is accepted on a rising edge where in_valid and
//   in_ready are both 1. in_ready is 1 only in IDLE, and in_valid is
//   ignored in any other state, so upstream must hold its op until it is taken.
//   Output side: result and flags are offered while out_valid is 1. They stay
//   stable until a rising edge with out_ready=1 takes them, and the block
//   then returns to IDLE.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             branch,
  output logic             illegal,
  output logic [1:0]       stateDbg
);

  // Shift amount width is derived from the datapath width.
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] opAddu = 4'h0;
  localparam logic [3:0] opSub  = 4'h1;
  localparam logic [3:0] opXor  = 4'h2;
  localparam logic [3:0] opNot  = 4'h3;
  localparam logic [3:0] opSra  = 4'h4;
  localparam logic [3:0] opSro  = 4'h5;
  localparam logic [3:0] opSlg  = 4'h6;
  localparam logic [3:0] opSlo  = 4'h7;
  localparam logic [3:0] opBl   = 4'h8;
  localparam logic [3:0] opBmh  = 4'h9;
  localparam logic [3:0] opBr   = 4'hA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             inReadyReg;
  logic             outValidReg;
  logic [WIDTH-1:0] resultReg;
  logic             carryReg;
  logic             zeroReg;
  logic             branchReg;
  logic             illegalReg;
  logic [3:0]       opReg;
  logic [WIDTH-1:0] workReg;
  logic [SHW-1:0]   cnt;

  // Single-cycle datapath evaluated on the incoming op and operands.
  logic [WIDTH:0]   aluSum;
  logic [WIDTH-1:0] aluResult;
  logic             aluCarry;
  logic             aluBranch;
  logic             aluIllegal;
  logic             startShift;
  logic [SHW-1:0]   shAmt;

  // Iterative shifter step, direction chosen by the captured op.
  logic [WIDTH-1:0] shiftNext;
  logic             shiftOutBit;

  assign shAmt = b[SHW-1:0];

  // Decode and compute the result of every op that completes without shifting.
  always_comb begin
    aluSum     = {1'b0, a} + {1'b0, b};
    aluResult  = '0;
    aluCarry   = carryReg;
    aluBranch  = 1'b0;
    aluIllegal = 1'b0;
    startShift = 1'b0;
    case (op)
      opAddu: begin
        aluResult = aluSum[WIDTH-1:0];
        aluCarry  = aluSum[WIDTH];
      end
      opSub: begin
        aluResult = a - b;
        aluCarry  = (a < b);
      end
      opXor: aluResult = a ^ b;
      opNot: aluResult = ~a;
      opSra, opSlg: begin
        // A zero shift amount passes a through and leaves carry alone.
        aluResult  = a;
        startShift = (shAmt != '0);
      end
      opSro: begin
        aluResult = {carryReg, a[WIDTH-1:1]};
        aluCarry  = a[0];
      end
      opSlo: begin
        aluResult = {a[WIDTH-2:0], carryReg};
        aluCarry  = a[WIDTH-1];
      end
      opBl:  aluBranch = (a < b);
      opBmh: aluBranch = a[WIDTH-1];
      opBr:  aluBranch = 1'b1;
      default: aluIllegal = 1'b1;
    endcase
  end

  // One shifter step: SLG shifts left filling zero, SRA shifts right keeping the sign.
  always_comb begin
    shiftNext   = {workReg[WIDTH-1], workReg[WIDTH-1:1]};
    shiftOutBit = workReg[0];
    if (opReg == opSlg) begin
      shiftNext   = {workReg[WIDTH-2:0], 1'b0};
      shiftOutBit = workReg[WIDTH-1];
    end
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state       <= IDLE;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
      resultReg   <= '0;
      carryReg    <= 1'b0;
      zeroReg     <= 1'b0;
      branchReg   <= 1'b0;
      illegalReg  <= 1'b0;
      opReg       <= '0;
      workReg     <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opReg      <= op;
            workReg    <= a;
            cnt        <= shAmt;
            inReadyReg <= 1'b0;
            if (startShift) begin
              state <= SHIFT;
            end else begin
              state       <= DONE;
              outValidReg <= 1'b1;
              resultReg   <= aluResult;
              carryReg    <= aluCarry;
              zeroReg     <= (aluResult == '0);
              branchReg   <= aluBranch;
              illegalReg  <= aluIllegal;
            end
          end
        end
        SHIFT: begin
          workReg <= shiftNext;
          cnt     <= cnt - SHW'(1);
          // The last step's outgoing bit becomes the new carry.
          if (cnt == SHW'(1)) begin
            state       <= DONE;
            outValidReg <= 1'b1;
            resultReg   <= shiftNext;
            carryReg    <= shiftOutBit;
            zeroReg     <= (shiftNext == '0);
            branchReg   <= 1'b0;
            illegalReg  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          outValidReg <= 1'b0;
          inReadyReg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = inReadyReg;
  assign out_valid = outValidReg;
  assign result    = resultReg;
  assign carry     = carryReg;
  assign zero      = zeroReg;
  assign branch    = branchReg;
  assign illegal   = illegalReg;
  assign stateDbg  = state;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq at WIDTH=8: directed vectors, randomized ops against a
// behavioural model, backpressure, mid-operation reset and back-to-back issue.
module tb_alu_seq;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         branch;
  logic         illegal;
  logic [1:0]   stateDbg;

  int checks = 0;
  int errors = 0;
  logic expCarry;
  logic [W+3:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero),
    .branch(branch), .illegal(illegal), .stateDbg(stateDbg)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {result, carry, zero, branch, illegal}.
  function automatic logic [W+3:0] model(input logic [3:0] mop, input logic [W-1:0] ma,
                                         input logic [W-1:0] mb, input logic cin,
                                         output logic cout, output int lat);
    logic [W-1:0] r;
    logic c, br, ill;
    int n;
    n = int'(mb[2:0]);
    r = '0; c = cin; br = 1'b0; ill = 1'b0; lat = 1;
    case (mop)
      4'h0: begin r = ma + mb; c = (int'(ma) + int'(mb)) >= (1 << W); end
      4'h1: begin r = ma - mb; c = (ma < mb); end
      4'h2: r = ma ^ mb;
      4'h3: r = ~ma;
      4'h4: begin
        if (n == 0) r = ma;
        else begin r = $signed(ma) >>> n; c = ma[n-1]; lat = 1 + n; end
      end
      4'h5: begin r = {cin, ma[W-1:1]}; c = ma[0]; end
      4'h6: begin
        if (n == 0) r = ma;
        else begin r = ma << n; c = ma[W-n]; lat = 1 + n; end
      end
      4'h7: begin r = {ma[W-2:0], cin}; c = ma[W-1]; end
      4'h8: br = (ma < mb);
      4'h9: br = ma[W-1];
      4'hA: br = 1'b1;
      default: ill = 1'b1;
    endcase
    cout = c;
    return {r, c, (r == '0), br, ill};
  endfunction

  // Driver: issue one op, wait for the result, capture it, then hand it off.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W+3:0] obs, output int lat);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!in_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!out_valid && lat < 50);
    if (guard >= 50) lat = -1;
    obs = {result, carry, zero, branch, illegal};
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({in_ready, out_valid, result, carry, zero, branch, illegal} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h",
               {in_ready, out_valid, result, carry, zero, branch, illegal}, {1'b1, 1'b0, 8'h00, 4'b0000});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle got=%b%b exp=01", out_valid, in_ready);
    end
    expCarry = 1'b0;
  endtask

  // Directed vectors with hand-computed expectations, starting from carry=0.
  logic [3:0]   dOp  [12] = '{4'h0, 4'h2, 4'h1, 4'h7, 4'h4, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'h6, 4'h5};
  logic [W-1:0] dA   [12] = '{8'hF0, 8'h55, 8'h03, 8'h81, 8'h90, 8'h90, 8'h02, 8'h7F, 8'h00, 8'h00, 8'h83, 8'h02};
  logic [W-1:0] dB   [12] = '{8'h20, 8'h55, 8'h05, 8'h00, 8'h03, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00};
  logic [W+3:0] dExp [12] = '{12'h108, 12'h00C, 12'hFE8, 12'h038, 12'hF20, 12'h900,
                              12'h006, 12'h004, 12'h006, 12'h005, 12'h808, 12'h810};
  int           dLat [12] = '{1, 1, 1, 1, 4, 1, 1, 1, 1, 1, 8, 1};

  task automatic test_directed();
    logic [W+3:0] obs;
    int lat;
    for (int i = 0; i < 12; i++) begin
      run_op(dOp[i], dA[i], dB[i], obs, lat);
      checks++;
      if (obs !== dExp[i]) begin
        errors++;
        $display("FAIL directed_%0d op=%h got=%h exp=%h", i, dOp[i], obs, dExp[i]);
      end
      checks++;
      if (lat !== dLat[i]) begin
        errors++;
        $display("FAIL directed_lat_%0d op=%h got=%0d exp=%0d", i, dOp[i], lat, dLat[i]);
      end
    end
    expCarry = 1'b0;
  endtask

  task automatic test_random();
    logic [W+3:0] obs, e;
    logic [3:0] o;
    logic [W-1:0] x, y;
    int lat, expLat;
    logic nc;
    for (int i = 0; i < 80; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = W'($urandom);
      exp_q.push_back(model(o, x, y, expCarry, nc, expLat));
      expCarry = nc;
      run_op(o, x, y, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random_%0d op=%h a=%h b=%h got=%h exp=%h", i, o, x, y, obs, e);
      end
      checks++;
      if (lat !== expLat) begin
        errors++;
        $display("FAIL random_lat_%0d op=%h b=%h got=%0d exp=%0d", i, o, y, lat, expLat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+3:0] e;
    logic nc;
    int lat, guard;
    e = model(4'h0, 8'h0F, 8'h01, expCarry, nc, lat);
    expCarry = nc;
    @(negedge CLK);
    op = 4'h0; a = 8'h0F; b = 8'h01; in_valid = 1'b1;
    @(posedge CLK);
    #1 op = 4'h3; a = 8'h00; b = 8'h00;  // held in_valid must be ignored in DONE
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!out_valid && guard < 50);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, result, carry, zero, branch, illegal} !== {2'b10, e}) begin
        errors++;
        $display("FAIL backpressure_%0d got=%h exp=%h", i,
                 {out_valid, in_ready, result, carry, zero, branch, illegal}, {2'b10, e});
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_no_extra_%0d got=%b exp=0", i, out_valid);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [W+3:0] obs;
    int lat;
    int seen;
    // Set carry so that clearing it by reset is observable.
    run_op(4'h0, 8'hFF, 8'h01, obs, lat);
    checks++;
    if (obs !== 12'h00C) begin
      errors++;
      $display("FAIL midop_setup got=%h exp=00c", obs);
    end
    @(negedge CLK);
    op = 4'h6; a = W'($urandom); b = 8'h07; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    checks++;
    if ({out_valid, carry, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midop_reset got=%b exp=001", {out_valid, carry, in_ready});
    end
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midop_no_result got=%0d exp=0", seen);
    end
    expCarry = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] e, obs;
    logic [3:0] o;
    logic [W-1:0] x, y;
    logic nc;
    int expLat;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = W'($urandom);
      if (o == 4'h4 || o == 4'h6) y[2:0] = 3'b000;
      exp_q.push_back(model(o, x, y, expCarry, nc, expLat));
      expCarry = nc;
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready);
      end
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge CLK);
      obs = {result, carry, zero, branch, illegal};
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, obs} !== {1'b1, e}) begin
        errors++;
        $display("FAIL b2b_%0d op=%h got=%h exp=%h", i, o, {out_valid, obs}, {1'b1, e});
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got=%b exp=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
